// File: rtl/servant_gpio_pkg.sv
// Shared register map and address field layout for the servant GPIO bank.
// Imported by the bank top and its per-port register block.
package servant_gpio_pkg;

    localparam int MAX_PORTS    = 16;
    localparam int ADR_REG_LSB  = 2;
    localparam int ADR_PORT_LSB = 5;

    typedef enum logic [2:0] {
        REG_OUT  = 3'd0,
        REG_SET  = 3'd1,
        REG_CLR  = 3'd2,
        REG_IN   = 3'd3,
        REG_EN   = 3'd4,
        REG_PEND = 3'd5,
        REG_EDGE = 3'd6,
        REG_RSVD = 3'd7
    } gpio_reg_e;

endpackage

// File: rtl/servant_gpio_port.sv
// One GPIO port: OUT/IN/IRQ_EN/IRQ_PEND/EDGE_SEL registers,
// per-bit edge detection and the port's read mux.
module servant_gpio_port
    import servant_gpio_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] OUT_RESET = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr,
    input  logic [2:0]       sel,
    input  logic [WIDTH-1:0] wdat,
    input  logic             in_upd,
    input  logic [WIDTH-1:0] in_val,
    output logic [WIDTH-1:0] out,
    output logic [31:0]      rdata,
    output logic             irq
);

    gpio_reg_e        reg_sel;
    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] in_q;
    logic [WIDTH-1:0] en_q;
    logic [WIDTH-1:0] pend_q;
    logic [WIDTH-1:0] edge_q;
    logic [WIDTH-1:0] hit_q;
    logic [WIDTH-1:0] w1c;

    assign reg_sel = gpio_reg_e'(sel);
    assign w1c     = (wr && reg_sel == REG_PEND) ? wdat : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_q  <= OUT_RESET;
            in_q   <= '0;
            en_q   <= '0;
            pend_q <= '0;
            edge_q <= '0;
            hit_q  <= '0;
        end else begin
            if (wr) begin
                unique case (reg_sel)
                    REG_OUT:  out_q  <= wdat;
                    REG_SET:  out_q  <= out_q | wdat;
                    REG_CLR:  out_q  <= out_q & ~wdat;
                    REG_EN:   en_q   <= wdat;
                    REG_EDGE: edge_q <= wdat;
                    default:  ;
                endcase
            end
            if (in_upd) begin
                in_q  <= in_val;
                hit_q <= (edge_q & in_q & ~in_val) |
                         (~edge_q & ~in_q & in_val);
            end else begin
                hit_q <= '0;
            end
            // A fresh hit beats a concurrent W1C on the same bit
            pend_q <= (pend_q & ~w1c) | (hit_q & en_q);
        end
    end

    always_comb begin
        rdata = '0;
        unique case (reg_sel)
            REG_OUT:  rdata[WIDTH-1:0] = out_q;
            REG_IN:   rdata[WIDTH-1:0] = in_q;
            REG_EN:   rdata[WIDTH-1:0] = en_q;
            REG_PEND: rdata[WIDTH-1:0] = pend_q;
            REG_EDGE: rdata[WIDTH-1:0] = edge_q;
            default:  rdata = '0;
        endcase
    end

    assign out = out_q;
    assign irq = |pend_q;

endmodule

// File: rtl/servant_gpio_bank.sv
// Parametrised GPIO bank on the servant ext bus: bus decode and ack,
// input-clock synchroniser, output-update strobe, NPORTS port blocks.
module servant_gpio_bank
    import servant_gpio_pkg::*;
#(
    parameter int               NPORTS      = 9,
    parameter int               WIDTH       = 32,
    parameter logic [WIDTH-1:0] OUT_RESET   = '0,
    parameter int               SYNC_STAGES = 2
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic [31:0]             i_wb_adr,
    input  logic [31:0]             i_wb_dat,
    input  logic                    i_wb_we,
    input  logic                    i_wb_cyc,
    output logic [31:0]             o_wb_rdt,
    output logic                    o_wb_ack,
    output logic [NPORTS*WIDTH-1:0] o_gpio_out,
    output logic                    o_gpio_out_clk,
    input  logic [NPORTS*WIDTH-1:0] i_gpio_in,
    input  logic                    i_gpio_in_clk,
    output logic                    o_irq,
    output logic [NPORTS-1:0]       o_irq_port
);

    logic [3:0]             port_idx;
    logic [2:0]             reg_sel;
    logic                   port_ok;
    logic                   ack_q;
    logic [31:0]            rdt_q;
    logic                   wr_en;
    logic                   wr_out;
    logic                   strobe_q;
    logic                   out_clk_q;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_last_q;
    logic                   in_upd;
    logic [31:0]            rd [NPORTS];
    logic [31:0]            rd_sel;
    logic                   unused_bits;

    assign port_idx = i_wb_adr[ADR_PORT_LSB +: 4];
    assign reg_sel  = i_wb_adr[ADR_REG_LSB +: 3];
    assign port_ok  = {1'b0, port_idx} < 5'(NPORTS);
    assign wr_en    = i_wb_cyc & ack_q & i_wb_we & port_ok;
    assign wr_out   = wr_en & (reg_sel == REG_OUT ||
                               reg_sel == REG_SET ||
                               reg_sel == REG_CLR);

    assign unused_bits = ^{i_wb_adr[31:9], i_wb_adr[1:0], i_wb_dat};

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            ack_q     <= 1'b0;
            rdt_q     <= '0;
            strobe_q  <= 1'b0;
            out_clk_q <= 1'b0;
        end else begin
            ack_q     <= i_wb_cyc & ~ack_q;
            rdt_q     <= (i_wb_cyc & ~ack_q) ? rd_sel : '0;
            strobe_q  <= wr_out;
            out_clk_q <= strobe_q;
        end
    end

    // Input clock is asynchronous; its rising edge after sync loads IN
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            sync_q      <= '0;
            sync_last_q <= 1'b0;
        end else begin
            sync_q      <= {sync_q[SYNC_STAGES-2:0], i_gpio_in_clk};
            sync_last_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign in_upd = sync_q[SYNC_STAGES-1] & ~sync_last_q;

    for (genvar p = 0; p < NPORTS; p++) begin : g_port
        servant_gpio_port #(
            .WIDTH     (WIDTH),
            .OUT_RESET (OUT_RESET)
        ) u_port (
            .clk    (i_clk),
            .rst_n  (i_rst_n),
            .wr     (wr_en && port_idx == 4'(p)),
            .sel    (reg_sel),
            .wdat   (i_wb_dat[WIDTH-1:0]),
            .in_upd (in_upd),
            .in_val (i_gpio_in[p*WIDTH +: WIDTH]),
            .out    (o_gpio_out[p*WIDTH +: WIDTH]),
            .rdata  (rd[p]),
            .irq    (o_irq_port[p])
        );
    end

    always_comb begin
        rd_sel = '0;
        for (int p = 0; p < NPORTS; p++) begin
            if (port_idx == 4'(p)) rd_sel = rd[p];
        end
    end

    assign o_wb_ack       = ack_q;
    assign o_wb_rdt       = rdt_q;
    assign o_gpio_out_clk = out_clk_q;
    assign o_irq          = |o_irq_port;

endmodule

// File: tb/tb_servant_gpio_bank.sv
// Directed self-checking bench for servant_gpio_bank (9 ports x 32 bits).
// Covers reset, set/clear aliases, strobe, edge IRQs, invalid port, reset.
module tb_servant_gpio_bank;

    localparam int NP = 9;
    localparam int W  = 32;
    localparam int SS = 2;
    localparam logic [W-1:0] RSTV = 32'hA5;

    logic            clk;
    logic            rst_n;
    logic [31:0]     wb_adr;
    logic [31:0]     wb_dat;
    logic            wb_we;
    logic            wb_cyc;
    logic [31:0]     wb_rdt;
    logic            wb_ack;
    logic [NP*W-1:0] gpio_out;
    logic            gpio_out_clk;
    logic [NP*W-1:0] gpio_in;
    logic            gpio_in_clk;
    logic            irq;
    logic [NP-1:0]   irq_port;

    int checks;
    int errors;
    int pulses;

    servant_gpio_bank #(
        .NPORTS      (NP),
        .WIDTH       (W),
        .OUT_RESET   (RSTV),
        .SYNC_STAGES (SS)
    ) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_wb_adr       (wb_adr),
        .i_wb_dat       (wb_dat),
        .i_wb_we        (wb_we),
        .i_wb_cyc       (wb_cyc),
        .o_wb_rdt       (wb_rdt),
        .o_wb_ack       (wb_ack),
        .o_gpio_out     (gpio_out),
        .o_gpio_out_clk (gpio_out_clk),
        .i_gpio_in      (gpio_in),
        .i_gpio_in_clk  (gpio_in_clk),
        .o_irq          (irq),
        .o_irq_port     (irq_port)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) if (gpio_out_clk === 1'b1) pulses++;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] adr(input int p, input int r);
        return 32'((p << 5) | (r << 2));
    endfunction

    task automatic wb(input int p, input int r, input logic we,
                      input logic [31:0] dat, output logic [31:0] rd);
        int n;
        @(negedge clk);
        wb_cyc = 1'b1;
        wb_we  = we;
        wb_adr = adr(p, r);
        wb_dat = dat;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!wb_ack && n < 4);
        chk("ack_lat", 64'(n), 64'd1);
        rd = wb_rdt;
        @(posedge clk);
        #1;
        chk("ack_drop", 64'(wb_ack), 64'd0);
        wb_cyc = 1'b0;
        wb_we  = 1'b0;
    endtask

    task automatic wr(input int p, input int r, input logic [31:0] d);
        logic [31:0] rd;
        wb(p, r, 1'b1, d, rd);
    endtask

    task automatic rdc(input string tag, input int p, input int r,
                       input logic [31:0] exp);
        logic [31:0] rd;
        wb(p, r, 1'b0, 32'h0, rd);
        chk(tag, 64'(rd), 64'(exp));
    endtask

    // Write an OUT alias and check value change then strobe one cycle later
    task automatic wr_out(input int r, input logic [31:0] d,
                          input logic [31:0] exp);
        wr(3, r, d);
        chk("out_val", 64'(gpio_out[3*W +: W]), 64'(exp));
        chk("oclk_lo0", 64'(gpio_out_clk), 64'd0);
        @(posedge clk); #1;
        chk("oclk_hi", 64'(gpio_out_clk), 64'd1);
        @(posedge clk); #1;
        chk("oclk_lo1", 64'(gpio_out_clk), 64'd0);
    endtask

    task automatic pin(input logic [31:0] v);
        @(negedge clk);
        gpio_in[5*W +: W] = v;
        gpio_in_clk = 1'b1;
        @(negedge clk);
        gpio_in_clk = 1'b0;
    endtask

    task automatic settle();
        repeat (4) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int p0;
        logic [NP*W-1:0] snap;
        checks = 0;
        errors = 0;
        pulses = 0;
        rst_n = 1'b0;
        wb_adr = '0;
        wb_dat = '0;
        wb_we = 1'b0;
        wb_cyc = 1'b0;
        gpio_in = '0;
        gpio_in_clk = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int p = 0; p < NP; p++)
            chk("rst_out", 64'(gpio_out[p*W +: W]), 64'h A5);
        chk("rst_irq", 64'(irq), 64'd0);
        chk("rst_irqp", 64'(irq_port), 64'd0);
        chk("rst_oclk", 64'(gpio_out_clk), 64'd0);
        rdc("rst_in", 5, 3, 32'h0);
        rdc("rst_pend", 5, 5, 32'h0);
        rdc("rst_rd_out", 0, 0, 32'hA5);

        p0 = pulses;
        wr_out(0, 32'h0000_1234, 32'h0000_1234);
        wr_out(1, 32'h000F_0000, 32'h000F_1234);
        wr_out(2, 32'h0000_0004, 32'h000F_1230);
        rdc("p3_out", 3, 0, 32'h000F_1230);
        rdc("p3_set_rd", 3, 1, 32'h0);
        rdc("p3_rsvd", 3, 7, 32'h0);
        chk("p2_out", 64'(gpio_out[2*W +: W]), 64'hA5);
        chk("p4_out", 64'(gpio_out[4*W +: W]), 64'hA5);
        chk("pulse_cnt", 64'(pulses - p0), 64'd3);

        p0 = pulses;
        wr(5, 4, 32'h1);
        wr(5, 6, 32'h0);
        rdc("p5_en", 5, 4, 32'h1);
        pin(32'h0);
        settle();
        chk("no_irq", 64'(irq), 64'd0);
        pin(32'h1);
        n = 1;
        while (!irq && n < 8) begin
            @(posedge clk); #1;
            n++;
        end
        chk("irq_lat", 64'(n <= SS + 2), 64'd1);
        chk("irq", 64'(irq), 64'd1);
        chk("irq_port", 64'(irq_port), 64'h020);
        rdc("p5_in", 5, 3, 32'h1);
        rdc("p5_pend", 5, 5, 32'h1);
        chk("no_pulse_en", 64'(pulses - p0), 64'd0);
        wr(5, 5, 32'h1);
        rdc("w1c_clr", 5, 5, 32'h0);
        chk("irq_clr", 64'(irq), 64'd0);

        wr(5, 6, 32'h1);
        pin(32'h0);
        settle();
        rdc("fall_set", 5, 5, 32'h1);
        wr(5, 4, 32'h0);
        rdc("en_off_keep", 5, 5, 32'h1);
        wr(5, 4, 32'h1);
        wr(5, 5, 32'h1);
        rdc("fall_clr", 5, 5, 32'h0);
        pin(32'h1);
        settle();
        rdc("rise_ign", 5, 5, 32'h0);

        // W1C lands on the same edge that applies a new falling hit
        @(negedge clk);
        gpio_in[5*W +: W] = 32'h0;
        gpio_in_clk = 1'b1;
        @(negedge clk);
        gpio_in_clk = 1'b0;
        @(negedge clk);
        wb_cyc = 1'b1;
        wb_we = 1'b1;
        wb_adr = adr(5, 5);
        wb_dat = 32'h1;
        @(posedge clk); #1;
        chk("w1c_ack", 64'(wb_ack), 64'd1);
        @(posedge clk); #1;
        wb_cyc = 1'b0;
        wb_we = 1'b0;
        rdc("set_wins", 5, 5, 32'h1);
        chk("set_wins_irq", 64'(irq), 64'd1);

        snap = gpio_out;
        p0 = pulses;
        wr(12, 0, 32'hFFFF_FFFF);
        settle();
        chk("p12_noeff", 64'(gpio_out == snap), 64'd1);
        chk("p12_nopulse", 64'(pulses - p0), 64'd0);
        rdc("p12_rd", 12, 0, 32'h0);

        @(negedge clk);
        wb_cyc = 1'b1;
        wb_we = 1'b1;
        wb_adr = adr(0, 0);
        wb_dat = 32'h55;
        @(posedge clk); #1;
        chk("ra_ack", 64'(wb_ack), 64'd1);
        p0 = pulses;
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("ra_ack0", 64'(wb_ack), 64'd0);
        chk("ra_p0", 64'(gpio_out[0*W +: W]), 64'hA5);
        chk("ra_p3", 64'(gpio_out[3*W +: W]), 64'hA5);
        chk("ra_irq", 64'(irq), 64'd0);
        wb_cyc = 1'b0;
        wb_we = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("ra_nopulse", 64'(pulses - p0), 64'd0);
        chk("ra_oclk", 64'(gpio_out_clk), 64'd0);
        rdc("ra_pend", 5, 5, 32'h0);
        rdc("ra_en", 5, 4, 32'h0);
        rdc("ra_in", 5, 3, 32'h0);
        rdc("ra_out0", 0, 0, 32'hA5);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
